// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC update sequencer: fetch/data-wait/redirect-flush/halt control
// Steers the PC enable and next-PC source, inserts flush bubbles after redirects, counts stalls.
module pc_sequencer #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN,
    input  logic             dWEN,
    input  logic             halt,
    input  logic             stall,
    input  logic             jr,
    input  logic             jump,
    input  logic             br_taken,
    output logic             pc_en,
    output logic [1:0]       pcsrc,
    output logic             bubble,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DWAIT  = 2'd1,
        S_REDIR  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [2:0] LP_FLUSH = 3'(FLUSH_CYCLES);

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_fcnt;
    logic [2:0]         w_fcnt_next;
    logic               r_flush;
    logic               r_halted;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_stall_inc;

    always_comb begin
        w_next      = r_state;
        w_fcnt_next = r_fcnt;
        pc_en       = 1'b0;
        pcsrc       = 2'd3;
        bubble      = 1'b0;
        case (r_state)
            S_RUN: begin
                if (ihit) begin
                    if (halt) begin
                        w_next = S_HALTED;
                    end else if (dREN || dWEN) begin
                        w_next = S_DWAIT;
                    end else if (stall) begin
                        w_next = S_RUN;
                    end else if (jr || jump || br_taken) begin
                        pc_en       = 1'b1;
                        pcsrc       = jr ? 2'd0 : (jump ? 2'd1 : 2'd2);
                        w_next      = S_REDIR;
                        w_fcnt_next = LP_FLUSH;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            S_DWAIT: begin
                if (dhit) begin
                    pc_en  = 1'b1;
                    w_next = S_RUN;
                end
            end
            S_REDIR: begin
                bubble      = 1'b1;
                pc_en       = ihit;
                w_fcnt_next = r_fcnt - 3'd1;
                // Counter holds the flush cycles still to run, including this one.
                if (r_fcnt <= 3'd1) begin
                    w_next = S_RUN;
                end
            end
            S_HALTED: begin
                w_next = S_HALTED;
            end
        endcase
        if (!nRST) begin
            pc_en       = 1'b0;
            pcsrc       = 2'd3;
            bubble      = 1'b0;
            w_next      = S_RUN;
            w_fcnt_next = 3'd0;
        end
    end

    assign w_stall_inc = nRST && !pc_en && ((r_state == S_RUN) || (r_state == S_DWAIT));

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state     <= S_RUN;
            r_fcnt      <= 3'd0;
            r_flush     <= 1'b0;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state  <= w_next;
            r_fcnt   <= w_fcnt_next;
            r_flush  <= (w_next == S_REDIR);
            r_halted <= (w_next == S_HALTED);
            if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign flush       = r_flush;
    assign halted      = r_halted;
    assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with a behavioural model
module tb_pc_sequencer;

    localparam int FLUSH = 2;
    localparam int CW    = 4;
    localparam int SAT   = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          ihit = 1'b0, dhit = 1'b0, dREN = 1'b0, dWEN = 1'b0, halt = 1'b0;
    logic          stall = 1'b0, jr = 1'b0, jump = 1'b0, br_taken = 1'b0;
    logic          pc_en, bubble, flush, halted;
    logic [1:0]    pcsrc;
    logic [CW-1:0] stall_count;

    pc_sequencer #(.FLUSH_CYCLES(FLUSH), .CNT_W(CW)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
        .halt(halt), .stall(stall), .jr(jr), .jump(jump), .br_taken(br_taken),
        .pc_en(pc_en), .pcsrc(pcsrc), .bubble(bubble), .flush(flush),
        .halted(halted), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit       pc_en;
        bit [1:0] pcsrc;
        bit       bubble;
        bit       flush;
        bit       halted;
        int       sc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Reference model: plain flags and counters describing what the pipeline is doing.
    bit m_halted   = 0;
    bit m_waiting  = 0;
    int m_flush    = 0;
    int m_stalls   = 0;

    function automatic void check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    task automatic step(input bit r, input bit ih, input bit dh, input bit rd, input bit wr,
                        input bit hl, input bit st, input bit j_r, input bit jmp, input bit br);
        exp_t e;
        bit   stalled;
        @(posedge CLK);
        #1;
        nRST = r; ihit = ih; dhit = dh; dREN = rd; dWEN = wr; halt = hl;
        stall = st; jr = j_r; jump = jmp; br_taken = br;
        e.flush  = (m_flush > 0);
        e.halted = m_halted;
        e.sc     = m_stalls;
        e.pc_en  = 0;
        e.pcsrc  = 3;
        e.bubble = 0;
        stalled  = 0;
        if (!r) begin
            m_halted = 0; m_waiting = 0; m_flush = 0; m_stalls = 0;
        end else if (m_halted) begin
            e.pc_en = 0;
        end else if (m_flush > 0) begin
            e.bubble = 1;
            e.pc_en  = ih;
            m_flush  = m_flush - 1;
        end else if (m_waiting) begin
            e.pc_en = dh;
            if (dh) m_waiting = 0;
            else    stalled = 1;
        end else if (!ih) begin
            stalled = 1;
        end else if (hl) begin
            m_halted = 1; stalled = 1;
        end else if (rd || wr) begin
            m_waiting = 1; stalled = 1;
        end else if (st) begin
            stalled = 1;
        end else if (j_r || jmp || br) begin
            e.pc_en = 1;
            e.pcsrc = j_r ? 2'd0 : (jmp ? 2'd1 : 2'd2);
            m_flush = FLUSH;
        end else begin
            e.pc_en = 1;
        end
        if (stalled && m_stalls < SAT) m_stalls++;
        q.push_back(e);
    endtask

    task automatic idle(input bit ih);
        step(1, ih, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("pc_en", int'(pc_en), int'(e.pc_en));
            check("pcsrc", int'(pcsrc), int'(e.pcsrc));
            check("bubble", int'(bubble), int'(e.bubble));
            check("flush", int'(flush), int'(e.flush));
            check("halted", int'(halted), int'(e.halted));
            check("stall_count", int'(stall_count), e.sc);
        end
    end

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 1, 1, 1, 1, 1);
        idle(1);
        #1;
        check("reset_flush", int'(flush), 0);
        check("reset_halted", int'(halted), 0);
        check("reset_stall_count", int'(stall_count), 0);
        for (int i = 0; i < 3; i++) idle(1);
        // load with three data-miss cycles
        step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        #1;
        check("load_stall_count", int'(stall_count), 4);
        check("load_back_in_run", int'(pc_en), 1);
        // taken branch then flush window
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 1, 1, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        // redirect priority
        step(1, 1, 0, 0, 0, 0, 0, 1, 1, 1);
        idle(1); idle(1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1); idle(1);
        // halt beats jump and sticks
        step(1, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 11; i++) step(1, 1, 1, 1, 0, 0, 0, 1, 1, 1);
        #1;
        check("halt_sticky", int'(halted), 1);
        // saturation
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) idle(0);
        idle(0);
        #1;
        check("stall_saturated", int'(stall_count), SAT);
        // reset on first flush cycle
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        #1;
        check("redir_reset_flush", int'(flush), 0);
        check("redir_reset_bubble", int'(bubble), 0);
        check("redir_reset_pc_en", int'(pc_en), 0);
        // reset in DWAIT
        step(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 49) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0);
        end
        @(posedge CLK);
        @(posedge CLK);
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, meaning the number of flush cycles after a redirect (legal range 1..7).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the stall counter.
REQ-003 SHALL have the following ports:
- CLK  in  1  sole clock; all state updates on its rising edge.
- nRST  in  1  reset; synchronous and active-low.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- dREN  in  1  current instruction reads data memory.
- dWEN  in  1  current instruction writes data memory.
- halt  in  1  current instruction is HALT.
- stall  in  1  hazard stall request (load-use).
- jr  in  1  current instruction is JR.
- jump  in  1  current instruction is J or JAL.
- br_taken  in  1  current instruction is BEQ or BNE, and the condition is true.
- pc_en  out  1  enable for the PC register.
- pcsrc  out  2  next-PC select: 0 = JR, 1 = J/JAL, 2 = branch, 3 = PC+4.
- bubble  out  1  PC loads its registered next value.
- flush  out  1  kill the fetched instruction.
- halted  out  1  sticky halt indication.
- stall_count  out  CNT_W  saturating count of stalled cycles.

Function
REQ-004 SHALL implement a four-state FSM: RUN, DWAIT, REDIR, HALTED.
REQ-005 pc_en, pcsrc and bubble SHALL be combinational from the state and the inputs; flush, halted and stall_count SHALL be registered.
REQ-006 In RUN, when ihit=0, the block SHALL drive pc_en=0 and pcsrc=3, and SHALL stay in RUN.
REQ-007 In RUN with ihit=1, inputs SHALL be resolved in this fixed priority: halt > (dREN|dWEN) > stall > jr > jump > br_taken > sequential.
REQ-008 RUN, ihit=1, halt=1: pc_en=0; next state HALTED; halted=1 from the next cycle.
REQ-009 RUN, ihit=1, dREN|dWEN=1: pc_en=0; next state DWAIT.
REQ-010 RUN, ihit=1, stall=1: pc_en=0; state unchanged.
REQ-011 RUN, ihit=1, redirect (jr, jump or br_taken): pc_en=1 with pcsrc 0, 1 or 2 respectively; next state REDIR; flush counter loaded with FLUSH_CYCLES.
REQ-012 RUN, ihit=1, no other condition: pc_en=1, pcsrc=3.
REQ-013 In DWAIT, when dhit=0: pc_en=0 and pcsrc=3.
REQ-014 In DWAIT, when dhit=1: pc_en=1, pcsrc=3, next state RUN; ihit is ignored in DWAIT.
REQ-015 In REDIR, flush=1 and bubble=1 on every cycle.
REQ-016 In REDIR, pc_en=ihit and pcsrc=3.
REQ-017 In REDIR, the flush counter SHALL decrement each cycle; on the cycle it reaches 1, next state is RUN.
REQ-018 All jr/jump/br_taken/halt/dREN/dWEN/stall inputs SHALL be ignored in REDIR.
REQ-019 In HALTED: pc_en=0, pcsrc=3, halted=1; the FSM SHALL remain there until reset.
REQ-020 stall_count SHALL increment by 1 on every cycle in RUN or DWAIT where pc_en=0 and the state is not HALTED.
REQ-021 stall_count SHALL saturate at all-ones and SHALL NOT wrap.
REQ-022 If more than one of jr, jump and br_taken is asserted, only the highest-priority one SHALL select pcsrc; no error is flagged.
REQ-023 bubble and flush SHALL be 0 in every state except REDIR.

Reset
REQ-024 While nRST=0 at a rising CLK edge, the next state SHALL be RUN, with the flush counter, flush, halted and stall_count all 0.
REQ-025 During reset cycles, the combinational outputs SHALL be forced to pc_en=0, pcsrc=3 and bubble=0.
REQ-026 A reset asserted mid-DWAIT, mid-REDIR or in HALTED SHALL abandon the operation with no residual flush or halt.

Verification
REQ-027 Sequential fetch: ihit=1 for 4 cycles, no other inputs -> pc_en=1 and pcsrc=3 each cycle; stall_count=0.
REQ-028 Load: ihit=1 with dREN=1, then dhit=0 for 3 cycles, then dhit=1 -> pc_en 0,0,0,0,1; state RUN after; stall_count=4.
REQ-029 Taken branch with FLUSH_CYCLES=2: ihit=1 with br_taken=1 -> pc_en=1 and pcsrc=2. The next 2 cycles show flush=1 and bubble=1. Then RUN.
REQ-030 Priority: ihit=1 with jr=1, jump=1 and br_taken=1 together -> pcsrc=0. ihit=1 with halt=1 and jump=1 together -> pc_en=0, then halted=1, and halted stays 1 for 10 further cycles.
REQ-031 Saturation with CNT_W=4: hold ihit=0 for 20 cycles -> stall_count reaches 15 and stays 15.
REQ-032 Reset in REDIR: nRST=0 on the first flush cycle -> the next cycle shows flush=0, bubble=0, pc_en=0, and the state is RUN.
